// File: rtl/opcode_executor_if.sv
// Operand/opcode inputs and result/status outputs of the accumulator executor.
// The slave side is the executor; the master side is the decoder/display logic.
interface opcode_executor_if #(
   parameter int WIDTH = 8
);
   logic [2:0]       opcode;
   logic [WIDTH-1:0] user_in;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] rem;
   logic             ovf;
   logic             dz;
   logic             busy;
   logic             done;

   modport master (
      output opcode, user_in,
      input  acc, prev, rem, ovf, dz, busy, done
   );

   modport slave (
      input  opcode, user_in,
      output acc, prev, rem, ovf, dz, busy, done
   );
endinterface

// File: rtl/opcode_executor.sv
// Executes decoded button opcodes against a WIDTH-bit accumulator; add/sub/recall/load
// complete in one cycle, multiply and divide iterate WIDTH cycles (shift-add / restoring).
module opcode_executor #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   opcode_executor_if.slave  bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_e;

   typedef enum logic [2:0] {
      OP_ADD    = 3'b000,
      OP_SUB    = 3'b001,
      OP_MUL    = 3'b010,
      OP_DIV    = 3'b011,
      OP_RECALL = 3'b100,
      OP_LOAD   = 3'b101,
      OP_IDLE   = 3'b110,
      OP_RSVD   = 3'b111
   } op_e;

   state_e             r_state;
   op_e                r_opcode_q;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_prev;
   logic [WIDTH-1:0]   r_rem;
   logic               r_ovf;
   logic               r_dz;
   logic               r_busy;
   logic               r_done;
   logic [CW-1:0]      r_cnt;

   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_prod;

   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_divisor;
   logic [WIDTH-1:0]   r_div_rem;

   logic               w_accept;
   logic               w_last;
   logic [WIDTH:0]     w_add;
   logic [WIDTH-1:0]   w_sub;
   logic               w_borrow;
   logic [2*WIDTH-1:0] w_prod_nxt;
   logic [WIDTH:0]     w_rem_sh;
   logic [WIDTH:0]     w_diff;
   logic [WIDTH-1:0]   w_rem_nxt;
   logic [WIDTH-1:0]   w_quo_nxt;

   // A press is only taken on the edge where the previous cycle showed idle/display,
   // so a held button fires exactly once.
   always_comb begin
      w_accept   = (r_state == S_IDLE) && (r_opcode_q == OP_IDLE) && (bus.opcode <= 3'd5);
      w_last     = (r_cnt == CW'(WIDTH - 1));
      w_add      = {1'b0, r_acc} + {1'b0, bus.user_in};
      w_sub      = r_acc - bus.user_in;
      w_borrow   = (bus.user_in > r_acc);
      w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
      w_rem_sh   = {r_div_rem, r_quo[WIDTH-1]};
      w_diff     = w_rem_sh - {1'b0, r_divisor};
      // Trial subtraction went negative: restore the shifted remainder, quotient bit 0.
      w_rem_nxt  = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_quo_nxt  = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_opcode_q <= OP_RSVD;
         r_acc      <= '0;
         r_prev     <= '0;
         r_rem      <= '0;
         r_ovf      <= 1'b0;
         r_dz       <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_cnt      <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_prod     <= '0;
         r_quo      <= '0;
         r_divisor  <= '0;
         r_div_rem  <= '0;
      end else begin
         r_opcode_q <= op_e'(bus.opcode);
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_busy <= 1'b1;
                  case (op_e'(bus.opcode))
                     OP_ADD: begin
                        r_acc   <= w_add[WIDTH-1:0];
                        r_ovf   <= w_add[WIDTH];
                        r_prev  <= r_acc;
                        r_dz    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end
                     OP_SUB: begin
                        r_acc   <= w_sub;
                        r_ovf   <= w_borrow;
                        r_prev  <= r_acc;
                        r_dz    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end
                     OP_MUL: begin
                        r_mcand  <= {{WIDTH{1'b0}}, r_acc};
                        r_mplier <= bus.user_in;
                        r_prod   <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_MUL;
                     end
                     OP_DIV: begin
                        if (bus.user_in == '0) begin
                           r_dz    <= 1'b1;
                           r_ovf   <= 1'b0;
                           r_done  <= 1'b1;
                           r_state <= S_DONE;
                        end else begin
                           r_quo     <= r_acc;
                           r_divisor <= bus.user_in;
                           r_div_rem <= '0;
                           r_cnt     <= '0;
                           r_state   <= S_DIV;
                        end
                     end
                     OP_RECALL: begin
                        r_acc   <= r_prev;
                        r_prev  <= r_acc;
                        r_ovf   <= 1'b0;
                        r_dz    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end
                     OP_LOAD: begin
                        r_acc   <= bus.user_in;
                        r_prev  <= r_acc;
                        r_ovf   <= 1'b0;
                        r_dz    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end
                     default: ;
                  endcase
               end
            end
            S_MUL: begin
               r_prod   <= w_prod_nxt;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CW'(1);
               if (w_last) begin
                  r_acc   <= w_prod_nxt[WIDTH-1:0];
                  r_ovf   <= |w_prod_nxt[2*WIDTH-1:WIDTH];
                  r_prev  <= r_acc;
                  r_dz    <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DIV: begin
               r_quo     <= w_quo_nxt;
               r_div_rem <= w_rem_nxt;
               r_cnt     <= r_cnt + CW'(1);
               if (w_last) begin
                  r_acc   <= w_quo_nxt;
                  r_rem   <= w_rem_nxt;
                  r_prev  <= r_acc;
                  r_ovf   <= 1'b0;
                  r_dz    <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.acc  = r_acc;
   assign bus.prev = r_prev;
   assign bus.rem  = r_rem;
   assign bus.ovf  = r_ovf;
   assign bus.dz   = r_dz;
   assign bus.busy = r_busy;
   assign bus.done = r_done;

endmodule

// File: tb/tb_opcode_executor.sv
// Directed bench for opcode_executor: hand-computed results, flags and busy/done timing.
module tb_opcode_executor;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   int   n_edges;
   int   n_busy;

   opcode_executor_if #(.WIDTH(8)) bus ();

   opcode_executor #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] acc, input logic [7:0] prev,
                          input logic [7:0] rem, input logic ovf, input logic dz,
                          input logic busy, input logic done);
      chk({tag, ".acc"},  32'(bus.acc),  32'(acc));
      chk({tag, ".prev"}, 32'(bus.prev), 32'(prev));
      chk({tag, ".rem"},  32'(bus.rem),  32'(rem));
      chk({tag, ".ovf"},  32'(bus.ovf),  32'(ovf));
      chk({tag, ".dz"},   32'(bus.dz),   32'(dz));
      chk({tag, ".busy"}, 32'(bus.busy), 32'(busy));
      chk({tag, ".done"}, 32'(bus.done), 32'(done));
   endtask

   task automatic press(input logic [2:0] op, input logic [7:0] val);
      bus.opcode  = op;
      bus.user_in = val;
      step();
   endtask

   task automatic release_btn();
      bus.opcode = 3'b110;
      step();
   endtask

   // Steps until done (bounded); counts edges after accept and cycles with busy high.
   task automatic wait_done(input bit toggle, input bit scramble, output int n, output int b);
      n = 0;
      b = (bus.busy === 1'b1) ? 1 : 0;
      while (bus.done !== 1'b1 && n < 40) begin
         if (toggle) bus.opcode = (n % 2 == 0) ? 3'b000 : 3'b110;
         else        bus.opcode = 3'b110;
         if (scramble) bus.user_in = 8'hFF;
         step();
         n++;
         if (bus.busy === 1'b1) b++;
      end
      bus.opcode = 3'b110;
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      bus.opcode  = 3'b110;
      bus.user_in = 8'h00;
      #12;
      chk_all("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      rst_n = 1'b1;
      step();

      // Load 0x0A: results and done/busy one cycle after accept, idle next cycle.
      press(3'b101, 8'h0A);
      chk_all("load0A", 8'h0A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      release_btn();
      chk("load0A.idle.busy", 32'(bus.busy), 32'd0);
      chk("load0A.idle.done", 32'(bus.done), 32'd0);

      press(3'b000, 8'hFB);
      chk_all("addFB", 8'h05, 8'h0A, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
      release_btn();
      press(3'b001, 8'h06);
      chk_all("sub06", 8'hFF, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
      release_btn();

      press(3'b101, 8'h0C);
      release_btn();
      press(3'b010, 8'h0D);
      chk("mul0D.start.busy", 32'(bus.busy), 32'd1);
      chk("mul0D.start.done", 32'(bus.done), 32'd0);
      wait_done(1'b0, 1'b0, n_edges, n_busy);
      chk("mul0D.latency", 32'(n_edges), 32'd8);
      chk("mul0D.busycycles", 32'(n_busy), 32'd9);
      chk_all("mul0D", 8'h9C, 8'h0C, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      step();
      chk("mul0D.idle.busy", 32'(bus.busy), 32'd0);

      // Operand changes after accept must not affect the product.
      press(3'b010, 8'h02);
      wait_done(1'b0, 1'b1, n_edges, n_busy);
      chk("mul02.latency", 32'(n_edges), 32'd8);
      chk_all("mul02", 8'h38, 8'h9C, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
      step();

      press(3'b101, 8'h64);
      release_btn();
      press(3'b011, 8'h07);
      wait_done(1'b0, 1'b0, n_edges, n_busy);
      chk("div07.latency", 32'(n_edges), 32'd8);
      chk("div07.busycycles", 32'(n_busy), 32'd9);
      chk_all("div07", 8'h0E, 8'h64, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1);
      step();

      press(3'b011, 8'h00);
      chk_all("div00", 8'h0E, 8'h64, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1);
      release_btn();
      chk("div00.idle.busy", 32'(bus.busy), 32'd0);

      press(3'b100, 8'h00);
      chk_all("recall", 8'h64, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1);
      release_btn();

      press(3'b101, 8'h00);
      release_btn();
      // Held add button executes once.
      press(3'b000, 8'h01);
      chk("hold.first.acc", 32'(bus.acc), 32'h01);
      chk("hold.first.done", 32'(bus.done), 32'd1);
      for (int i = 0; i < 19; i++) step();
      chk_all("hold", 8'h01, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
      release_btn();

      press(3'b010, 8'h05);
      wait_done(1'b1, 1'b0, n_edges, n_busy);
      chk("toggle.latency", 32'(n_edges), 32'd8);
      chk_all("toggle", 8'h05, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1);
      step();
      step();
      chk_all("toggle.after", 8'h05, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a multiply, with the mult button held across release.
      press(3'b010, 8'h03);
      for (int i = 0; i < 4; i++) step();
      chk("midreset.busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_all("midreset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk_all("heldthroughreset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.opcode = 3'b110;
      step();
      press(3'b010, 8'h07);
      chk("postreset.accept.busy", 32'(bus.busy), 32'd1);
      wait_done(1'b0, 1'b0, n_edges, n_busy);
      chk("postreset.latency", 32'(n_edges), 32'd8);
      chk_all("postreset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/opcode_executor.md
# opcode_executor

Consumes the 3-bit opcode stream produced by the button instruction decoder and executes it against an 8-bit accumulator. Each operation runs once per button press: single-cycle for add, subtract, recall and load, and multi-cycle iterative for multiply and divide. The block reports results, flags and busy/done status to the display and register logic downstream.

## Interface
Parameters:
- WIDTH, 8, datapath width; multiply and divide take WIDTH iteration cycles.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  3  decoder output, refreshed every cycle.
  - 000 add, 001 sub, 010 mult, 011 div, 100 recall, 101 load, 110 idle/display, 111 reserved.
- user_in  in  WIDTH  switch operand.
- acc  out  WIDTH  accumulator (result).
- prev  out  WIDTH  previous result.
- rem  out  WIDTH  remainder of the last successful divide.
- ovf  out  1  overflow/carry/borrow flag of the last operation.
- dz  out  1  divide-by-zero flag of the last operation.
- busy  out  1  high whenever the FSM is not IDLE.
- done  out  1  one-cycle pulse when an operation completes.

## Operation
- opcode_q: register that samples opcode every cycle.
- Accept condition: state==IDLE, opcode_q==110, and opcode in 000..101.
  - A held button executes exactly once.
  - 111 is never accepted.
  - Opcode activity while busy is ignored. Acceptance still requires opcode_q==110 once IDLE.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: on accept of 000/001/100/101, update results at the accept edge and go to DONE.
  - IDLE: on accept of 010, or of 011 with user_in!=0, go to MUL or DIV.
  - IDLE: on accept of 011 with user_in==0, set dz=1, ovf=0, leave acc/prev/rem unchanged, go to DONE.
  - MUL/DIV: run WIDTH iterations with a counter of 0..WIDTH-1. On the last iteration, write the result and go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Add: acc<=acc+user_in mod 2^WIDTH; ovf=carry out; prev<=old acc; dz=0.
- Sub: acc<=acc-user_in mod 2^WIDTH; ovf=1 iff user_in>acc (borrow); prev<=old acc; dz=0.
- Mult: shift-add over a 2*WIDTH product.
  - acc<=product[WIDTH-1:0]; ovf=1 iff the upper half is nonzero.
  - prev<=old acc; dz=0.
- Div: restoring division of acc by user_in. Operands are latched at accept.
  - acc<=quotient, rem<=remainder, prev<=old acc; ovf=0, dz=0.
- Recall (100): swap acc and prev; ovf=0, dz=0.
- Load (101): acc<=user_in, prev<=old acc; ovf=0, dz=0.
- Operand latching: user_in and acc are latched at accept for MUL/DIV. Later user_in changes do not affect the result.
- Reset values: acc=0, prev=0, rem=0, ovf=0, dz=0, busy=0, done=0, state=IDLE.
  - opcode_q resets to 111, so an op opcode held through reset release is not executed until 110 is seen.
- Reset asserted mid-operation aborts immediately. No partial result is written.

## Timing
- Edge A is the accept edge.
- Single-cycle ops and div-by-zero: results are visible after A. busy and done are high in cycle A+1; IDLE at A+2.
- Mult and div: busy is high from A+1. Results are written at edge A+WIDTH and become visible with done in cycle A+WIDTH+1. IDLE follows one edge later.
  - busy lasts WIDTH+1 cycles; 9 for WIDTH=8.
- The earliest next accept is 1 cycle after returning to IDLE, provided opcode_q==110.
- acc, prev, rem and the flags are registered and hold between operations.

## Test plan
- Reset, then opcode 110→101 with user_in=0x0A -> acc=0x0A, prev=0x00, done pulse exactly 1 cycle after accept.
- From acc=0x0A, add with user_in=0xFB -> acc=0x05, ovf=1, prev=0x0A; a following sub of 0x06 -> acc=0xFF, ovf=1.
- Load 0x0C, then mult with user_in=0x0D -> acc=0x9C, ovf=0, busy for 9 cycles, done at A+9.
  - Then mult by 0x02 -> acc=0x38, ovf=1.
- Load 0x64, then div by 0x07 -> acc=0x0E, rem=0x02.
  - Then div by 0x00 -> acc=0x0E unchanged, rem=0x02 unchanged, dz=1, done at A+1.
- Hold opcode 000 for 20 cycles with user_in=0x01 from acc=0 -> acc=0x01 (single execution).
  - Toggle opcode 110/000 during a mult -> those presses are ignored.
- Assert rst_n low at iteration 4 of a mult -> all outputs are 0 immediately.
  - Hold opcode 010 through reset release -> no execution until 110 is then 010.
